// File: rtl/rtc_write_sequencer_if.sv
// rtl/rtc_write_sequencer_if.sv - four-phase RTC register write bus between sequencer and bus driver
interface rtc_write_sequencer_if;
    logic [7:0] Addr;
    logic [7:0] Data_out;
    logic       Wr_req;
    logic       Wr_ack;

    modport master (
        output Addr,
        output Data_out,
        output Wr_req,
        input  Wr_ack
    );

    modport slave (
        input  Addr,
        input  Data_out,
        input  Wr_req,
        output Wr_ack
    );
endinterface

// File: rtl/rtc_write_sequencer.sv
// rtl/rtc_write_sequencer.sv - snapshots six clamped time fields and writes each, BCD-encoded, to the RTC
module rtc_write_sequencer #(
    parameter logic [7:0] ADDR_SEG  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HORA = 8'h23,
    parameter logic [7:0] ADDR_DIA  = 8'h24,
    parameter logic [7:0] ADDR_MES  = 8'h25,
    parameter logic [7:0] ADDR_AO   = 8'h26,
    parameter int         TIMEOUT   = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [6:0]            Seg,
    input  logic [6:0]            Min,
    input  logic [6:0]            Hora,
    input  logic [6:0]            Dia,
    input  logic [6:0]            Mes,
    input  logic [6:0]            Ao,
    output logic [6:0]            Ref,
    input  logic [7:0]            Dato_bcd,
    rtc_write_sequencer_if.master bus,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_LOAD,
        S_REQ,
        S_REL,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [5:0][6:0] snap_q, snap_d;
    logic [6:0]      ref_q, ref_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            wr_req_q, wr_req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    function automatic logic [6:0] clamp(input logic [6:0] v, input logic [6:0] lo,
                                         input logic [6:0] hi);
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic [7:0] field_addr(input logic [2:0] i);
        case (i)
            3'd0:    return ADDR_SEG;
            3'd1:    return ADDR_MIN;
            3'd2:    return ADDR_HORA;
            3'd3:    return ADDR_DIA;
            3'd4:    return ADDR_MES;
            default: return ADDR_AO;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        ref_d    = ref_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_req_d = wr_req_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    snap_d[0] = clamp(Seg,  7'd0, 7'd59);
                    snap_d[1] = clamp(Min,  7'd0, 7'd59);
                    snap_d[2] = clamp(Hora, 7'd0, 7'd23);
                    snap_d[3] = clamp(Dia,  7'd1, 7'd31);
                    snap_d[4] = clamp(Mes,  7'd1, 7'd12);
                    snap_d[5] = clamp(Ao,   7'd0, 7'd99);
                    idx_d     = 3'd0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SEL;
                end
            end
            S_SEL: begin
                ref_d   = snap_q[idx_q];
                state_d = S_WAIT;
            end
            // Decoder output is registered; give it one cycle to follow Ref.
            S_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                data_d   = Dato_bcd;
                addr_d   = field_addr(idx_q);
                wr_req_d = 1'b1;
                cnt_d    = 8'd0;
                state_d  = S_REQ;
            end
            S_REQ: begin
                if (Wr_ack_in()) begin
                    wr_req_d = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = S_REL;
                end else if (cnt_q == CNT_LAST) begin
                    wr_req_d = 1'b0;
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_REL: begin
                if (!Wr_ack_in()) begin
                    if (idx_q == 3'd5) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEL;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    function automatic logic Wr_ack_in();
        return bus.Wr_ack;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            snap_q   <= '0;
            ref_q    <= 7'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            ref_q    <= ref_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_req_q <= wr_req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign Ref          = ref_q;
    assign bus.Addr     = addr_q;
    assign bus.Data_out = data_q;
    assign bus.Wr_req   = wr_req_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// tb/tb_rtc_write_sequencer.sv - scoreboard bench for rtc_write_sequencer
module tb_rtc_write_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [6:0] Seg = '0, Min = '0, Hora = '0, Dia = '0, Mes = '0, Ao = '0;
    logic [6:0] Ref;
    logic [7:0] Dato_bcd = '0;
    logic       Busy, Done, Error;

    rtc_write_sequencer_if bus();

    rtc_write_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Seg      (Seg),
        .Min      (Min),
        .Hora     (Hora),
        .Dia      (Dia),
        .Mes      (Mes),
        .Ao       (Ao),
        .Ref      (Ref),
        .Dato_bcd (Dato_bcd),
        .bus      (bus),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [6:0] refv;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        if (v > 99)
            return 0;
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int clamp_field(input int i, input int v);
        case (i)
            0, 1:    return (v > 59) ? 59 : v;
            2:       return (v > 23) ? 23 : v;
            3:       return (v == 0) ? 1 : ((v > 31) ? 31 : v);
            4:       return (v == 0) ? 1 : ((v > 12) ? 12 : v);
            default: return (v > 99) ? 99 : v;
        endcase
    endfunction

    // Registered binary-to-BCD decoder the sequencer drives through Ref.
    always @(posedge Clock) Dato_bcd <= 8'(to_bcd(int'(Ref)));

    int ack_delay = 2;
    int rel_delay = 1;
    int stall_w   = 0;
    int rwrite    = 0;
    int rcnt      = 0;
    bit rphase    = 0;

    initial begin
        bus.Wr_ack = 1'b0;
        forever begin
            @(posedge Clock);
            #2;
            if (Reset) begin
                bus.Wr_ack = 1'b0;
                rphase = 0;
                rcnt = 0;
            end else if (!rphase) begin
                if (bus.Wr_req) begin
                    if (rcnt == 0) rwrite++;
                    rcnt++;
                    if (rcnt >= ack_delay && rwrite != stall_w) begin
                        bus.Wr_ack = 1'b1;
                        rphase = 1;
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end else if (!bus.Wr_req) begin
                rcnt++;
                if (rcnt >= rel_delay) begin
                    bus.Wr_ack = 1'b0;
                    rphase = 0;
                    rcnt = 0;
                end
            end
        end
    end

    int         writes = 0;
    int         dones = 0;
    int         req_len = 0;
    int         last_req_len = 0;
    logic       prev_req = 0, prev_done = 0, ack_prev = 0;
    logic [6:0] ref_h1 = '0, ref_h2 = '0;
    logic [7:0] rise_addr = '0, rise_data = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                if (bus.Wr_req && !prev_req) begin
                    writes++;
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_write", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("addr", bus.Addr, e.addr);
                        check_eq("data_bcd", bus.Data_out, e.data);
                        check_eq("ref_2_before_req", ref_h2, e.refv);
                        check_eq("ack_low_before_req", ack_prev, 1'b0);
                    end
                    rise_addr = bus.Addr;
                    rise_data = bus.Data_out;
                end
                if (!bus.Wr_req && prev_req) begin
                    last_req_len = req_len;
                    check_eq("addr_held", bus.Addr, rise_addr);
                    check_eq("data_held", bus.Data_out, rise_data);
                end
                req_len = bus.Wr_req ? req_len + 1 : 0;
                if (Done) begin
                    dones++;
                    check_eq("done_one_cycle", prev_done, 1'b0);
                end
            end else begin
                req_len = 0;
            end
            ref_h2    = ref_h1;
            ref_h1    = Ref;
            prev_req  = bus.Wr_req;
            prev_done = Done;
            ack_prev  = bus.Wr_ack;
        end
    end

    task automatic load_fields(input int s, input int m, input int h, input int d,
                               input int mo, input int a);
        int v[6];
        v = '{s, m, h, d, mo, a};
        Seg = 7'(s); Min = 7'(m); Hora = 7'(h); Dia = 7'(d); Mes = 7'(mo); Ao = 7'(a);
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.addr = 8'(8'h21 + i);
            e.refv = 7'(clamp_field(i, v[i]));
            e.data = 8'(to_bcd(clamp_field(i, v[i])));
            sb_q.push_back(e);
        end
    endtask

    task automatic scramble_fields();
        Seg = 7'($urandom_range(0, 127)); Min = 7'($urandom_range(0, 127));
        Hora = 7'($urandom_range(0, 127)); Dia = 7'($urandom_range(0, 127));
        Mes = 7'($urandom_range(0, 127)); Ao = 7'($urandom_range(0, 127));
    endtask

    task automatic start_seq(input int s, input int m, input int h, input int d,
                             input int mo, input int a);
        writes = 0; dones = 0; rwrite = 0;
        load_fields(s, m, h, d, mo, a);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        scramble_fields();
        check_eq("busy_after_start", Busy, 1'b1);
        check_eq("error_cleared_on_start", Error, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy && n < 4000) begin
            @(negedge Clock);
            n++;
        end
        if (Busy) check_eq("wait_idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge Clock);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {Ref, bus.Addr, bus.Data_out, bus.Wr_req, Busy, Done, Error}, '0);
    endtask

    task automatic check_full_run(input string tag);
        check_eq({tag, "_writes"}, writes, 6);
        check_eq({tag, "_dones"}, dones, 1);
        check_eq({tag, "_queue_empty"}, sb_q.size(), 0);
        check_eq({tag, "_busy_low"}, Busy, 1'b0);
        check_eq({tag, "_error_low"}, Error, 1'b0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clock);

        start_seq(45, 30, 12, 15, 6, 16);
        wait_idle();
        check_full_run("basic");

        start_seq(75, 60, 30, 0, 13, 120);
        wait_idle();
        check_full_run("clamp");

        stall_w = 3;
        start_seq(1, 2, 3, 4, 5, 6);
        wait_idle();
        check_eq("timeout_req_len", last_req_len, 255);
        check_eq("timeout_error", Error, 1'b1);
        check_eq("timeout_busy", Busy, 1'b0);
        check_eq("timeout_no_done", dones, 0);
        check_eq("timeout_writes", writes, 3);
        sb_q.delete();
        stall_w = 0;
        start_seq(59, 0, 23, 31, 12, 99);
        wait_idle();
        check_full_run("after_timeout");

        rel_delay = 10;
        writes = 0; dones = 0; rwrite = 0;
        load_fields(9, 8, 7, 6, 5, 4);
        Start = 1'b1;
        @(negedge Clock);
        scramble_fields();
        n = 0;
        while (Busy && n < 4000) begin
            @(negedge Clock);
            n++;
        end
        Start = 1'b0;
        if (Busy) check_eq("start_spam_timeout", 32'd1, 32'd0);
        repeat (5) @(negedge Clock);
        check_full_run("start_spam");
        rel_delay = 1;

        start_seq(10, 20, 21, 22, 11, 50);
        n = 0;
        while (!(writes == 3 && bus.Wr_req) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check_eq("reached_hora_write", writes, 3);
        Reset = 1'b1;
        @(negedge Clock);
        check_all_zero("mid_reset");
        Reset = 1'b0;
        sb_q.delete();
        repeat (5) @(negedge Clock);
        check_eq("mid_reset_no_done", dones, 0);
        start_seq(33, 44, 5, 28, 2, 0);
        wait_idle();
        check_full_run("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
